ecg_sample_capture: RTL and testbench
=====================================

// Module: ecg_sample_capture
// PURPOSE
// - Downstream consumer of the divided sample clock (smallClk) from the clock divider.
// - On each smallClk rising edge, captures one ECG ADC word into a small FIFO.
// - Presents the buffered samples on a valid/ready stream for the filter/QRS stages.
// - Whole block runs on bigClk. smallClk is a register output in the bigClk domain, so no synchronizer is used.
// PARAMETERS
// - DATA_W  12  ADC sample width in bits.
// - DEPTH   8   FIFO depth in words. Must be a power of 2 and >= 2.
// - DROP_W  8   width of the saturating dropped-sample counter.
// PORTS
// - bigClk       in   1                      system clock; every flop uses its rising edge.
// - rstN         in   1                      asynchronous, active-low reset.
// - smallClk     in   1                      divided sample clock; treated as a level and edge-detected.
// - adcData      in   DATA_W                 ADC word; must be stable in the cycle smallClk first reads high.
// - sampleData   out  DATA_W                 head-of-FIFO sample (first-word fall-through).
// - sampleValid  out  1                      high while the FIFO is non-empty.
// - sampleReady  in   1                      consumer accepts sampleData when valid && ready.
// - fillLevel    out  $clog2(DEPTH)+1        current FIFO occupancy, range 0..DEPTH.
// - overflow     out  1                      sticky; set on any dropped sample.
// - overflowClr  in   1                      synchronous clear of overflow and dropCount.
// - dropCount    out  DROP_W                 number of dropped samples; saturates at all-ones.
// BEHAVIOUR
// - Reset: while rstN=0, asynchronously clear:
//   - read and write pointers, fillLevel=0, sampleValid=0, sampleData=0 (the output mux is forced to 0 when empty);
//   - overflow=0, dropCount=0;
//   - prevSmall=1, so a smallClk that is already high at reset release does not produce a spurious capture.
// - Strobe: strobe = smallClk & ~prevSmall. prevSmall <= smallClk every cycle.
// - Capture: adcData is written in the same cycle the strobe is high.
//   - Write-to-valid latency is 1 cycle: strobe in cycle N gives sampleValid=1 in cycle N+1 if the FIFO was empty.
// - Pop: pop = sampleValid & sampleReady. The read pointer advances at the end of that cycle.
// - Push when full:
//   - a push is accepted if the FIFO is not full, or if the FIFO is full and a pop occurs in the same cycle (level unchanged);
//   - full with no pop: the sample is dropped, overflow <= 1, and dropCount increments unless it is at all-ones.
// - Simultaneous push and pop: on an empty FIFO, push only (pop cannot occur because valid=0).
//   - on a non-empty, non-full FIFO: fillLevel is unchanged and both pointers advance.
// - fillLevel arithmetic: fillLevel += push_accepted - pop. It never exceeds DEPTH and never goes below 0.
// - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
//   - full/empty are derived from fillLevel, not from pointer compare.
// - overflowClr and drop in the same cycle: the set wins.
//   - overflow=1 and dropCount=1 afterwards (the clear applies first, then the increment).
// - sampleData/sampleValid may change only after a pop or a push into an empty FIFO; they are stable while valid && !ready.
// - Reset asserted mid-stream: all buffered samples are discarded; no partial state survives.
// STRUCTURE
// - Package ecg_pkg: localparam ECG_DATA_W=12; typedef logic [ECG_DATA_W-1:0] ecg_sample_t.
//   - Shared with the divider and filter stages.
// - Sub-module sample_fifo: parameterised DATA_W/DEPTH synchronous FIFO with FWFT output.
//   - Ports: push, pop, wdata, rdata, level, full, empty.
// - Top level contains the edge detector, drop logic and counters, and instantiates sample_fifo.
// TESTING
// - Drive smallClk with a 6-cycle period (3 high/3 low), adcData=cycle index, sampleReady=1:
//   - one sample is delivered per smallClk rise, 1 cycle after the strobe; fillLevel never exceeds 1.
// - Hold sampleReady=0 for 9 smallClk rises with adcData=0x100+k:
//   - the first 8 words are stored in order and fillLevel=8;
//   - the 9th is dropped, overflow=1, dropCount=1;
//   - with ready raised, reads return 0x100..0x107.
// - Keep the FIFO full with ready=0 for 300 rises:
//   - dropCount saturates at 255;
//   - pulse overflowClr -> overflow=0 and dropCount=0 on the next cycle.
// - FIFO full; strobe and pop in the same cycle:
//   - fillLevel stays 8, no drop, the new word is appended at the tail.
// - Hold smallClk=1 across the rstN release:
//   - no capture until the next 0->1 transition;
//   - assert rstN=0 with 5 words buffered -> sampleValid=0 and fillLevel=0 immediately, with no clock edge.
// - smallClk held high for 10 cycles, then low:
//   - exactly one capture occurs (level, not pulse, input).

Source files
------------

// File: rtl/ecg_pkg.sv
// Shared ECG sample definitions for the divider, capture and filter stages.
package ecg_pkg;
  localparam int ECG_DATA_W = 12;
  typedef logic [ECG_DATA_W-1:0] ecg_sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with first-word fall-through output.
// Occupancy is tracked in a level counter; full/empty derive from it.
module sample_fifo
  import ecg_pkg::*;
#(
  parameter int DATA_W = ECG_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push, w_pop;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LVL_W'(DEPTH));
  // A push into a full FIFO is only legal when a pop frees the head slot.
  assign w_push = push & (~full | pop);
  assign w_pop  = pop & ~empty;
  assign level  = r_level;
  // Output is forced to zero while empty so stale words never show.
  assign rdata  = empty ? '0 : r_mem[r_rptr];

  // Storage write; no reset needed since empty masks the output.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers wrap modulo DEPTH; level moves by push - pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/ecg_sample_capture.sv
// Captures one ADC word per smallClk rising edge into a FWFT FIFO and
// streams it out on valid/ready. smallClk comes from a bigClk register,
// so it is edge-detected directly without synchronisation.
module ecg_sample_capture
  import ecg_pkg::*;
#(
  parameter int DATA_W = ECG_DATA_W,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                   bigClk,
  input  logic                   rstN,
  input  logic                   smallClk,
  input  logic [DATA_W-1:0]      adcData,
  output logic [DATA_W-1:0]      sampleData,
  output logic                   sampleValid,
  input  logic                   sampleReady,
  output logic [$clog2(DEPTH):0] fillLevel,
  output logic                   overflow,
  input  logic                   overflowClr,
  output logic [DROP_W-1:0]      dropCount
);
  logic              r_prevSmall;
  logic              r_overflow;
  logic [DROP_W-1:0] r_dropCnt;
  logic              w_strobe, w_pop, w_drop, w_full, w_empty;
  logic [DROP_W-1:0] w_cntBase, w_cntNext;

  assign w_strobe    = smallClk & ~r_prevSmall;
  assign w_pop       = ~w_empty & sampleReady;
  assign w_drop      = w_strobe & w_full & ~w_pop;
  assign sampleValid = ~w_empty;
  assign overflow    = r_overflow;
  assign dropCount   = r_dropCnt;

  // Edge detector history; resets high so a level already high is ignored.
  always_ff @(posedge bigClk or negedge rstN) begin
    if (!rstN) r_prevSmall <= 1'b1;
    else       r_prevSmall <= smallClk;
  end

  // Clear applies before a same-cycle drop increment; count saturates.
  always_comb begin
    w_cntBase = overflowClr ? '0 : r_dropCnt;
    w_cntNext = (&w_cntBase) ? w_cntBase : w_cntBase + DROP_W'(1);
  end

  // Sticky overflow flag and dropped-sample counter.
  always_ff @(posedge bigClk or negedge rstN) begin
    if (!rstN) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_dropCnt  <= w_cntNext;
    end else if (overflowClr) begin
      r_overflow <= 1'b0;
      r_dropCnt  <= '0;
    end
  end

  sample_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (bigClk),
    .rst_n(rstN),
    .push (w_strobe),
    .pop  (w_pop),
    .wdata(adcData),
    .rdata(sampleData),
    .level(fillLevel),
    .full (w_full),
    .empty(w_empty)
  );
endmodule

// File: tb/tb_ecg_sample_capture.sv
// Self-checking bench: queue-based reference model of the capture FIFO.
module tb_ecg_sample_capture;
  localparam int DW = 12;
  localparam int DEPTH = 8;

  logic          bigClk = 1'b0;
  logic          rstN = 1'b0;
  logic          smallClk = 1'b0;
  logic [DW-1:0] adcData = '0;
  logic [DW-1:0] sampleData;
  logic          sampleValid;
  logic          sampleReady = 1'b0;
  logic [3:0]    fillLevel;
  logic          overflow;
  logic          overflowClr = 1'b0;
  logic [7:0]    dropCount;

  int chk = 0;
  int err = 0;
  int cyc = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic          m_prev = 1'b1;
  logic          m_ovf = 1'b0;
  int            m_drops = 0;

  ecg_sample_capture dut (
    .bigClk(bigClk), .rstN(rstN), .smallClk(smallClk), .adcData(adcData),
    .sampleData(sampleData), .sampleValid(sampleValid), .sampleReady(sampleReady),
    .fillLevel(fillLevel), .overflow(overflow), .overflowClr(overflowClr),
    .dropCount(dropCount)
  );

  always #5 bigClk = ~bigClk;

  task automatic model_reset();
    mq.delete();
    m_prev = 1'b1;
    m_ovf = 1'b0;
    m_drops = 0;
  endtask

  // One clock of the abstract behaviour: pop head, then try to append.
  task automatic model_step();
    bit strobe;
    strobe = smallClk && !m_prev;
    if (mq.size() > 0 && sampleReady) void'(mq.pop_front());
    if (overflowClr) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    if (strobe) begin
      if (mq.size() < DEPTH) mq.push_back(adcData);
      else begin
        m_ovf = 1'b1;
        if (m_drops < 255) m_drops++;
      end
    end
    m_prev = smallClk;
  endtask

  task automatic tick();
    @(posedge bigClk);
    if (rstN) model_step();
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    rstN = 1'b0;
    smallClk = 1'b0;
    sampleReady = 1'b0;
    overflowClr = 1'b0;
    model_reset();
    tick();
    tick();
    rstN = 1'b1;
    tick();
  endtask

  // one smallClk period: 3 cycles high then 3 low
  task automatic rise(input logic [DW-1:0] d);
    adcData = d;
    smallClk = 1'b1;
    repeat (3) tick();
    smallClk = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    model_reset();
    #1;
    chk++; if (sampleValid !== 1'b0) begin err++; $display("FAIL rst_valid got %0b exp 0", sampleValid); end
    chk++; if (fillLevel !== 4'd0) begin err++; $display("FAIL rst_level got %0d exp 0", fillLevel); end
    chk++; if (sampleData !== 12'h0) begin err++; $display("FAIL rst_data got %0h exp 0", sampleData); end
    chk++; if (overflow !== 1'b0) begin err++; $display("FAIL rst_ovf got %0b exp 0", overflow); end
    chk++; if (dropCount !== 8'd0) begin err++; $display("FAIL rst_drop got %0d exp 0", dropCount); end
    apply_reset();
  endtask

  task automatic test_stream();
    int deliv = 0;
    apply_reset();
    sampleReady = 1'b1;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 6; c++) begin
        smallClk = (c < 3);
        adcData = DW'(cyc);
        tick();
        if (sampleValid) deliv++;
        chk++; if (sampleValid !== (mq.size() != 0)) begin err++; $display("FAIL stream_valid got %0b exp %0b", sampleValid, mq.size() != 0); end
        chk++; if (fillLevel > 4'd1) begin err++; $display("FAIL stream_level got %0d exp <=1", fillLevel); end
        if (mq.size() != 0) begin
          chk++; if (sampleData !== mq[0]) begin err++; $display("FAIL stream_data got %0h exp %0h", sampleData, mq[0]); end
        end
      end
    end
    chk++; if (deliv != 10) begin err++; $display("FAIL stream_count got %0d exp 10", deliv); end
  endtask

  task automatic test_fill_overflow();
    apply_reset();
    for (int k = 0; k < 9; k++) rise(DW'(12'h100 + k));
    chk++; if (fillLevel !== 4'd8) begin err++; $display("FAIL fill_level got %0d exp 8", fillLevel); end
    chk++; if (overflow !== 1'b1) begin err++; $display("FAIL fill_ovf got %0b exp 1", overflow); end
    chk++; if (dropCount !== 8'd1) begin err++; $display("FAIL fill_drop got %0d exp 1", dropCount); end
    sampleReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk++; if (sampleValid !== 1'b1 || sampleData !== DW'(12'h100 + k)) begin
        err++; $display("FAIL fill_read%0d got %0b/%0h exp 1/%0h", k, sampleValid, sampleData, 12'h100 + k);
      end
      tick();
    end
    chk++; if (sampleValid !== 1'b0) begin err++; $display("FAIL fill_empty got %0b exp 0", sampleValid); end
    sampleReady = 1'b0;
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int k = 0; k < 308; k++) rise(DW'(k));
    chk++; if (dropCount !== 8'd255) begin err++; $display("FAIL sat_drop got %0d exp 255", dropCount); end
    chk++; if (fillLevel !== 4'd8) begin err++; $display("FAIL sat_level got %0d exp 8", fillLevel); end
    overflowClr = 1'b1;
    tick();
    overflowClr = 1'b0;
    chk++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin
      err++; $display("FAIL sat_clr got %0b/%0d exp 0/0", overflow, dropCount);
    end
    // clear and drop together: the drop wins after the clear
    overflowClr = 1'b1;
    smallClk = 1'b1;
    tick();
    overflowClr = 1'b0;
    chk++; if (overflow !== 1'b1 || dropCount !== 8'd1) begin
      err++; $display("FAIL clr_drop got %0b/%0d exp 1/1", overflow, dropCount);
    end
    smallClk = 1'b0;
    tick();
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    for (int k = 0; k < 8; k++) rise(DW'(12'h200 + k));
    adcData = 12'h2FF;
    smallClk = 1'b1;
    sampleReady = 1'b1;
    tick();
    sampleReady = 1'b0;
    chk++; if (fillLevel !== 4'd8) begin err++; $display("FAIL fpp_level got %0d exp 8", fillLevel); end
    chk++; if (overflow !== 1'b0 || dropCount !== 8'd0) begin
      err++; $display("FAIL fpp_nodrop got %0b/%0d exp 0/0", overflow, dropCount);
    end
    smallClk = 1'b0;
    tick();
    sampleReady = 1'b1;
    for (int k = 1; k < 9; k++) begin
      logic [DW-1:0] e;
      e = (k == 8) ? 12'h2FF : DW'(12'h200 + k);
      chk++; if (sampleData !== e) begin err++; $display("FAIL fpp_read%0d got %0h exp %0h", k, sampleData, e); end
      tick();
    end
    sampleReady = 1'b0;
  endtask

  task automatic test_reset_high();
    rstN = 1'b0;
    smallClk = 1'b1;
    sampleReady = 1'b0;
    model_reset();
    tick();
    rstN = 1'b1;
    adcData = 12'hABC;
    repeat (4) tick();
    chk++; if (sampleValid !== 1'b0) begin err++; $display("FAIL rsthi_nocap got %0b exp 0", sampleValid); end
    smallClk = 1'b0;
    tick();
    smallClk = 1'b1;
    tick();
    chk++; if (sampleValid !== 1'b1 || sampleData !== 12'hABC) begin
      err++; $display("FAIL rsthi_cap got %0b/%0h exp 1/abc", sampleValid, sampleData);
    end
    smallClk = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) rise(DW'(k));
    chk++; if (fillLevel !== 4'd5) begin err++; $display("FAIL rsthi_five got %0d exp 5", fillLevel); end
    rstN = 1'b0;
    model_reset();
    #1;
    chk++; if (sampleValid !== 1'b0 || fillLevel !== 4'd0) begin
      err++; $display("FAIL async_rst got %0b/%0d exp 0/0", sampleValid, fillLevel);
    end
    apply_reset();
  endtask

  task automatic test_level_hold();
    apply_reset();
    adcData = 12'h5A5;
    smallClk = 1'b1;
    repeat (10) tick();
    smallClk = 1'b0;
    repeat (3) tick();
    chk++; if (fillLevel !== 4'd1) begin err++; $display("FAIL hold_level got %0d exp 1", fillLevel); end
    chk++; if (sampleData !== 12'h5A5) begin err++; $display("FAIL hold_data got %0h exp 5a5", sampleData); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] ed;
      if ($urandom_range(0, 2) == 0) smallClk = ~smallClk;
      sampleReady = ($urandom_range(0, 2) == 0);
      overflowClr = ($urandom_range(0, 39) == 0);
      adcData = DW'($urandom);
      tick();
      ed = (mq.size() != 0) ? mq[0] : '0;
      chk++; if (sampleValid !== (mq.size() != 0)) begin err++; $display("FAIL rnd_valid c%0d got %0b exp %0b", cyc, sampleValid, mq.size() != 0); end
      chk++; if (sampleData !== ed) begin err++; $display("FAIL rnd_data c%0d got %0h exp %0h", cyc, sampleData, ed); end
      chk++; if (fillLevel !== 4'(mq.size())) begin err++; $display("FAIL rnd_level c%0d got %0d exp %0d", cyc, fillLevel, mq.size()); end
      chk++; if (overflow !== m_ovf) begin err++; $display("FAIL rnd_ovf c%0d got %0b exp %0b", cyc, overflow, m_ovf); end
      chk++; if (dropCount !== 8'(m_drops)) begin err++; $display("FAIL rnd_drop c%0d got %0d exp %0d", cyc, dropCount, m_drops); end
    end
    overflowClr = 1'b0;
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_fill_overflow();
    test_saturate();
    test_full_pop_push();
    test_reset_high();
    test_level_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
